sobel_sched: RTL and testbench
==============================

# sobel_sched

Memory-access scheduler and top-level sequencer for the edge-detection accelerator. On `start`, it walks the image stored in the single-port word memory and fetches the three vertically adjacent words (rows r-1, r, r+1) for every interior output word. It hands each 3-word window to the Sobel datapath over a valid/ready handshake, then writes the returned result word into the output image region. Border rows are zero-filled. `finish` is raised when the whole output image has been written.

## Interface
- `IMG_W_WORDS`, default 88: words per image row (4 pixels of 8 bits per word).
- `IMG_H`, default 288: image rows; must be ≥ 3.
- `OUT_BASE`, default 25344: word address of output row 0 (= `IMG_W_WORDS*IMG_H`).

Ports:
- `clk`  input  1  system clock; all logic on the rising edge.
- `reset`  input  1  synchronous, active-low reset.
- `start`  input  1  level; run begins on the first `start=1` seen in IDLE.
- `finish`  output  1  high in DONE.
- `addr`  output  16  memory word address.
- `en`  output  1  memory enable.
- `we`  output  1  memory write enable (valid only with `en`).
- `dataW`  output  32  memory write data.
- `dataR`  input  32  memory read data, valid the cycle after the read is issued.
- `win_valid`  output  1  window presented to the datapath.
- `win_ready`  input  1  datapath accepts the window.
- `win_top`, `win_mid`, `win_bot`  output  32 each  words from rows r-1, r, r+1.
- `win_col`  output  16  column word index c of the window.
- `res_valid`  input  1  datapath result available.
- `res_ready`  output  1  scheduler accepts the result.
- `res_data`  input  32  result word.

## Operation
- States: IDLE, BORDER_TOP, RD_TOP, RD_MID, RD_BOT, CAP, PRESENT, WAIT_RES, WRITE, BORDER_BOT, DONE.
- IDLE: `start=1` → BORDER_TOP with c=0.
- BORDER_TOP: one write per cycle, `addr=OUT_BASE+c`, `dataW=0`, for c=0..W-1. Then r=1, c=0 → RD_TOP.
- RD_TOP: read at `(r-1)*W+c`. RD_MID: read at `r*W+c` and capture `dataR` into `win_top`. RD_BOT: read at `(r+1)*W+c` and capture into `win_mid`. CAP: capture into `win_bot`, no memory access.
- PRESENT: `win_valid=1`, held with stable window data until `win_ready=1` → WAIT_RES.
- WAIT_RES: `res_ready=1`. On `res_valid=1`, register `res_data` → WRITE.
- WRITE: `addr=OUT_BASE+r*W+c`, `we=1`, `dataW`=registered result.
  - c<W-1 → c+1, RD_TOP.
  - Else r<H-2 → r+1, c=0, RD_TOP.
  - Else → BORDER_BOT with c=0.
- BORDER_BOT: zero-writes at `OUT_BASE+(H-1)*W+c`, c=0..W-1, then DONE.
- DONE: `finish=1` while `start=1`. `start=0` → IDLE. `start` must fall before a new run.
- Address math: maintain row base `rb=r*W` incrementally (add W per row, no multiplier). top=`rb-W`, bot=`rb+W`. All addresses fit in 16 bits unsigned for default parameters (max 50687).
- Only one window is in flight. The scheduler never issues a memory access in PRESENT or WAIT_RES.
- `start` changes outside IDLE and DONE are ignored.

## Timing
- Reset (`reset=0` at a clock edge) → IDLE next cycle. All outputs 0: `finish`, `en`, `we`, `addr`, `dataW`, `win_*`, `res_ready`. Counters are cleared.
- Reset mid-run aborts with no further memory accesses. A partially written output is permitted.
- Memory outputs are registered. The access is seen by memory on the edge ending the state.
- Minimum of 7 cycles per interior word when `win_ready` and `res_valid` are already high.
- `win_valid` stays high until the handshake completes. `res_ready` is asserted only in WAIT_RES.
- Simultaneous `win_ready` with `win_valid`: transfer happens in that cycle.
- Total minimum run for defaults: 2·88 + 286·88·7 + 1 cycles before `finish`.

## Structure
- `edge_pkg` holds:
  - the state enum `sched_state_t`;
  - default constants `IMG_W_WORDS`, `IMG_H`, `OUT_BASE`;
  - address width `AW=16` and data width `DW=32`.
- One sub-module, `sobel_addr_gen`, owns the row/column counters, `rb`, and the top/mid/bot/out address outputs. It has `clr`, `next_col`, and `next_row` strobes and `last_col`/`last_row` flags.
- The FSM and the handshake registers stay in `sobel_sched`.

## Test plan
- W=2, H=4, memory words 0..7 = 1..8, datapath model returns `top+mid+bot` with `win_ready=res_valid=1`:
  - out[8..9]=0;
  - out[10]=1+3+5=9, out[11]=12;
  - out[12]=15, out[13]=18;
  - out[14..15]=0;
  - `finish` at cycle 2+4·7+2+1 after start.
- Datapath holds `win_ready=0` for 5 cycles on the first window → `win_valid` and window data stable for 5 cycles, no `en` pulses, results unchanged.
- `res_valid` delayed 3 cycles → `res_ready` high 4 cycles, a single write with the correct data.
- Reset asserted during WAIT_RES → next cycle all outputs 0, state IDLE. The following `start` reruns and produces the identical image.
- Default 88×288 `pattern.pgm` with the real datapath → dumped image matches the golden file. Every address stays < 50688.
- `start` held high after `finish` → `finish` stays 1 and there is no restart. `start` low → IDLE, `finish`=0.

Source files
------------

// File: rtl/edge_pkg.sv
// Shared types and default geometry for the edge-detection accelerator.
package edge_pkg;
    localparam int AW          = 16;
    localparam int DW          = 32;
    localparam int IMG_W_WORDS = 88;
    localparam int IMG_H       = 288;
    localparam int OUT_BASE    = IMG_W_WORDS * IMG_H;

    typedef enum logic [3:0] {
        S_IDLE,
        S_BORDER_TOP,
        S_RD_TOP,
        S_RD_MID,
        S_RD_BOT,
        S_CAP,
        S_PRESENT,
        S_WAIT_RES,
        S_WRITE,
        S_BORDER_BOT,
        S_DONE
    } sched_state_t;
endpackage

// File: rtl/sobel_sched_if.sv
// Memory port plus window/result handshakes between the scheduler and its neighbours.
interface sobel_sched_if;
    import edge_pkg::*;

    logic [AW-1:0] addr;
    logic          en;
    logic          we;
    logic [DW-1:0] dataW;
    logic [DW-1:0] dataR;
    logic          win_valid;
    logic          win_ready;
    logic [DW-1:0] win_top;
    logic [DW-1:0] win_mid;
    logic [DW-1:0] win_bot;
    logic [AW-1:0] win_col;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_data;

    modport master (
        output addr, en, we, dataW,
        input  dataR,
        output win_valid, win_top, win_mid, win_bot, win_col,
        input  win_ready,
        input  res_valid, res_data,
        output res_ready
    );

    modport slave (
        input  addr, en, we, dataW,
        output dataR,
        input  win_valid, win_top, win_mid, win_bot, win_col,
        output win_ready,
        output res_valid, res_data,
        input  res_ready
    );
endinterface

// File: rtl/sobel_addr_gen.sv
// Row/column counters and word addresses. Address outputs describe the position the
// counters will hold after this edge, so the scheduler can register them one state ahead.
module sobel_addr_gen
    import edge_pkg::*;
#(
    parameter int W  = IMG_W_WORDS,
    parameter int H  = IMG_H,
    parameter int OB = OUT_BASE
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          next_col,
    input  logic          next_row,
    output logic          last_col,
    output logic          last_row,
    output logic [AW-1:0] col,
    output logic [AW-1:0] top,
    output logic [AW-1:0] mid,
    output logic [AW-1:0] bot,
    output logic [AW-1:0] out
);
    localparam logic [AW-1:0] W_A    = AW'(W);
    localparam logic [AW-1:0] OB_A   = AW'(OB);
    localparam logic [AW-1:0] LAST_C = AW'(W - 1);
    localparam logic [AW-1:0] LAST_R = AW'(H - 2);

    logic [AW-1:0] r_c, r_r, r_rb;
    logic [AW-1:0] w_c_nxt, w_r_nxt, w_rb_nxt;

    always_comb begin
        w_c_nxt  = r_c;
        w_r_nxt  = r_r;
        w_rb_nxt = r_rb;
        if (clr) begin
            w_c_nxt  = '0;
            w_r_nxt  = '0;
            w_rb_nxt = '0;
        end else if (next_row) begin
            w_c_nxt  = '0;
            w_r_nxt  = r_r + 1'b1;
            w_rb_nxt = r_rb + W_A;
        end else if (next_col) begin
            w_c_nxt  = r_c + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_c  <= '0;
            r_r  <= '0;
            r_rb <= '0;
        end else begin
            r_c  <= w_c_nxt;
            r_r  <= w_r_nxt;
            r_rb <= w_rb_nxt;
        end
    end

    assign last_col = (r_c == LAST_C);
    assign last_row = (r_r == LAST_R);
    assign col      = r_c;
    // Top address underflows only while r=0, where it is never used.
    assign mid      = w_rb_nxt + w_c_nxt;
    assign top      = mid - W_A;
    assign bot      = mid + W_A;
    assign out      = mid + OB_A;
endmodule

// File: rtl/sobel_sched.sv
// Sequencer: zero-fills border rows, fetches 3-row windows, hands them to the
// Sobel datapath and writes each returned word into the output image.
module sobel_sched
    import edge_pkg::*;
#(
    parameter int IMG_W_WORDS = edge_pkg::IMG_W_WORDS,
    parameter int IMG_H       = edge_pkg::IMG_H,
    parameter int OUT_BASE    = edge_pkg::OUT_BASE
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          finish,
    sobel_sched_if.master bus
);
    sched_state_t  r_state;
    logic          r_finish, r_en, r_we, r_win_valid, r_res_ready;
    logic [AW-1:0] r_addr, r_win_col;
    logic [DW-1:0] r_dataW, r_win_top, r_win_mid, r_win_bot;

    logic          w_clr, w_step, w_next_col, w_next_row, w_last_col, w_last_row;
    logic [AW-1:0] w_col, w_top, w_mid, w_bot, w_out;

    // Counters advance on the same edge that leaves a write state.
    always_comb begin
        w_clr      = (r_state == S_IDLE);
        w_step     = (r_state == S_BORDER_TOP) || (r_state == S_WRITE) ||
                     ((r_state == S_BORDER_BOT) && !w_last_col);
        w_next_row = w_step && w_last_col && (r_state != S_BORDER_BOT);
        w_next_col = w_step && !w_last_col;
    end

    sobel_addr_gen #(
        .W  (IMG_W_WORDS),
        .H  (IMG_H),
        .OB (OUT_BASE)
    ) u_addr (
        .clk      (clk),
        .reset    (reset),
        .clr      (w_clr),
        .next_col (w_next_col),
        .next_row (w_next_row),
        .last_col (w_last_col),
        .last_row (w_last_row),
        .col      (w_col),
        .top      (w_top),
        .mid      (w_mid),
        .bot      (w_bot),
        .out      (w_out)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_finish    <= 1'b0;
            r_en        <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_dataW     <= '0;
            r_win_valid <= 1'b0;
            r_win_top   <= '0;
            r_win_mid   <= '0;
            r_win_bot   <= '0;
            r_win_col   <= '0;
            r_res_ready <= 1'b0;
        end else begin
            r_en    <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_dataW <= '0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_state <= S_BORDER_TOP;
                    r_en    <= 1'b1;
                    r_we    <= 1'b1;
                    r_addr  <= w_out;
                end
                S_BORDER_TOP: begin
                    r_en <= 1'b1;
                    if (w_last_col) begin
                        r_state <= S_RD_TOP;
                        r_addr  <= w_top;
                    end else begin
                        r_we   <= 1'b1;
                        r_addr <= w_out;
                    end
                end
                S_RD_TOP: begin
                    r_state <= S_RD_MID;
                    r_en    <= 1'b1;
                    r_addr  <= w_mid;
                end
                S_RD_MID: begin
                    r_state   <= S_RD_BOT;
                    r_win_top <= bus.dataR;
                    r_en      <= 1'b1;
                    r_addr    <= w_bot;
                end
                S_RD_BOT: begin
                    r_state   <= S_CAP;
                    r_win_mid <= bus.dataR;
                end
                S_CAP: begin
                    r_state     <= S_PRESENT;
                    r_win_bot   <= bus.dataR;
                    r_win_col   <= w_col;
                    r_win_valid <= 1'b1;
                end
                S_PRESENT: if (bus.win_ready) begin
                    r_state     <= S_WAIT_RES;
                    r_win_valid <= 1'b0;
                    r_res_ready <= 1'b1;
                end
                S_WAIT_RES: if (bus.res_valid) begin
                    r_state     <= S_WRITE;
                    r_res_ready <= 1'b0;
                    r_en        <= 1'b1;
                    r_we        <= 1'b1;
                    r_addr      <= w_out;
                    r_dataW     <= bus.res_data;
                end
                S_WRITE: begin
                    r_en <= 1'b1;
                    if (w_last_col && w_last_row) begin
                        r_state <= S_BORDER_BOT;
                        r_we    <= 1'b1;
                        r_addr  <= w_out;
                    end else begin
                        r_state <= S_RD_TOP;
                        r_addr  <= w_top;
                    end
                end
                S_BORDER_BOT: begin
                    if (w_last_col) begin
                        r_state  <= S_DONE;
                        r_finish <= 1'b1;
                    end else begin
                        r_en   <= 1'b1;
                        r_we   <= 1'b1;
                        r_addr <= w_out;
                    end
                end
                S_DONE: if (!start) begin
                    r_state  <= S_IDLE;
                    r_finish <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign finish        = r_finish;
    assign bus.addr      = r_addr;
    assign bus.en        = r_en;
    assign bus.we        = r_we;
    assign bus.dataW     = r_dataW;
    assign bus.win_valid = r_win_valid;
    assign bus.win_top   = r_win_top;
    assign bus.win_mid   = r_win_mid;
    assign bus.win_bot   = r_win_bot;
    assign bus.win_col   = r_win_col;
    assign bus.res_ready = r_res_ready;
endmodule

// File: tb/tb_sobel_sched.sv
// Small-image bench: 2x4 words, sum-of-rows datapath model, write/window scoreboards.
module tb_sobel_sched;
    import edge_pkg::*;

    localparam int W  = 2;
    localparam int H  = 4;
    localparam int OB = 8;
    localparam int NW = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic finish;

    always #5 clk = ~clk;

    sobel_sched_if bus();

    sobel_sched #(.IMG_W_WORDS(W), .IMG_H(H), .OUT_BASE(OB)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .finish (finish),
        .bus    (bus)
    );

    typedef struct packed { logic [15:0] addr; logic [31:0] data; } wr_t;
    typedef struct packed { logic [31:0] t, m, b; logic [15:0] c; } win_t;
    typedef struct { int addr; logic [31:0] exp; } vec_t;

    logic [31:0] mem [NW];
    logic [31:0] img [NW];
    wr_t  wq[$];
    win_t winq[$];
    vec_t img_tbl[8];

    int n_cmp = 0;
    int n_err = 0;
    int rr_cnt = 0;
    int stall_left = 0;
    int dly_next = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Single-port memory with one-cycle read latency.
    always @(posedge clk) begin
        if (bus.en) begin
            if (bus.we) mem[bus.addr[3:0]] <= bus.dataW;
            else        bus.dataR <= mem[bus.addr[3:0]];
        end
    end

    // Write scoreboard and address bound.
    always @(negedge clk) begin
        if (reset && bus.en) begin
            chk("addr_bound", 128'(bus.addr < 16'(NW)), 128'(1));
            if (bus.we) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", 128'(bus.addr), 128'hFFFF);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    chk("write_addr", 128'(bus.addr), 128'(e.addr));
                    chk("write_data", 128'(bus.dataW), 128'(e.data));
                end
            end
        end
    end

    always @(negedge clk) if (bus.res_ready) rr_cnt++;

    // Datapath model: optional stall on ready, optional result delay, returns top+mid+bot.
    initial begin : dp
        bit busy;
        bit have_snap;
        int dly;
        logic [31:0] sum;
        win_t snap, cur, e;
        busy = 0; have_snap = 0; dly = 0; sum = 0; snap = '0;
        bus.win_ready = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_data  = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                busy = 0; have_snap = 0;
                bus.win_ready = 1'b0;
                bus.res_valid = 1'b0;
            end else if (bus.res_valid) begin
                bus.res_valid = 1'b0;
                busy = 0;
            end else if (busy) begin
                bus.win_ready = 1'b0;
                if (dly > 0) dly--;
                else begin
                    bus.res_valid = 1'b1;
                    bus.res_data  = sum;
                end
            end else if (bus.win_valid) begin
                cur = {bus.win_top, bus.win_mid, bus.win_bot, bus.win_col};
                if (stall_left > 0) begin
                    if (have_snap) chk("stall_window", 128'(cur), 128'(snap));
                    else begin snap = cur; have_snap = 1; end
                    chk("stall_no_en", 128'(bus.en), 128'(0));
                    stall_left--;
                end else begin
                    have_snap = 0;
                    if (winq.size() == 0) chk("unexpected_window", 128'(cur), 128'(0));
                    else begin
                        e = winq.pop_front();
                        chk("window", 128'(cur), 128'(e));
                    end
                    sum = cur.t + cur.m + cur.b;
                    bus.win_ready = 1'b1;
                    busy = 1;
                    dly = dly_next;
                    dly_next = 0;
                end
            end
        end
    end

    task automatic push_expect();
        for (int c = 0; c < W; c++) wq.push_back({16'(OB + c), 32'h0});
        for (int r = 1; r <= H - 2; r++)
            for (int c = 0; c < W; c++) begin
                win_t wn;
                wn = {img[(r-1)*W+c], img[r*W+c], img[(r+1)*W+c], 16'(c)};
                winq.push_back(wn);
                wq.push_back({16'(OB + r*W + c), wn.t + wn.m + wn.b});
            end
        for (int c = 0; c < W; c++) wq.push_back({16'(OB + (H-1)*W + c), 32'h0});
    endtask

    task automatic clear_out();
        for (int i = OB; i < NW; i++) mem[i] = 32'hDEAD_BEEF;
    endtask

    task automatic run_img(input int exp_cyc);
        int cnt;
        push_expect();
        @(negedge clk);
        start = 1'b1;
        cnt = 0;
        do begin
            @(posedge clk);
            cnt++;
            #1;
        end while (!finish && cnt < 500);
        chk("finish_cycles", 128'(cnt), 128'(exp_cyc));
        repeat (6) begin
            @(negedge clk);
            chk("finish_hold", 128'(finish), 128'(1));
            chk("no_restart_en", 128'(bus.en), 128'(0));
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("finish_clear", 128'(finish), 128'(0));
        chk("wq_empty", 128'(wq.size()), 128'(0));
        chk("winq_empty", 128'(winq.size()), 128'(0));
    endtask

    task automatic check_image();
        for (int i = 0; i < 8; i++)
            chk($sformatf("img[%0d]", img_tbl[i].addr), 128'(mem[img_tbl[i].addr]), 128'(img_tbl[i].exp));
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_finish"}, 128'(finish), 128'(0));
        chk({tag, "_mem"}, {bus.en, bus.we, bus.addr, bus.dataW}, 128'(0));
        chk({tag, "_win"}, {bus.win_valid, bus.win_top, bus.win_mid, bus.win_bot, bus.win_col}, 128'(0));
        chk({tag, "_res_ready"}, 128'(bus.res_ready), 128'(0));
    endtask

    initial begin
        img_tbl[0] = '{8, 32'd0};   img_tbl[1] = '{9, 32'd0};
        img_tbl[2] = '{10, 32'd9};  img_tbl[3] = '{11, 32'd12};
        img_tbl[4] = '{12, 32'd15}; img_tbl[5] = '{13, 32'd18};
        img_tbl[6] = '{14, 32'd0};  img_tbl[7] = '{15, 32'd0};
        for (int i = 0; i < NW; i++) begin
            img[i] = (i < OB) ? 32'(i + 1) : 32'h0;
            mem[i] = img[i];
        end
        clear_out();

        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        @(negedge clk);
        reset = 1'b1;

        // Nominal: 7 cycles per interior word.
        rr_cnt = 0;
        run_img(33);
        chk("res_ready_cycles_nominal", 128'(rr_cnt), 128'(4));
        check_image();

        // Stalled first window, delayed first result.
        clear_out();
        stall_left = 5;
        dly_next = 3;
        rr_cnt = 0;
        run_img(41);
        chk("res_ready_cycles_delayed", 128'(rr_cnt), 128'(7));
        check_image();

        // Reset while waiting for a result, then a clean rerun.
        clear_out();
        push_expect();
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 200 && !bus.res_ready; i++) @(negedge clk);
        chk("reach_wait_res", 128'(bus.res_ready), 128'(1));
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        check_zero_outputs("midrun_reset");
        start = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("reset_no_en", 128'(bus.en), 128'(0));
        end
        reset = 1'b1;
        wq.delete();
        winq.delete();
        rr_cnt = 0;
        run_img(33);
        check_image();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
